game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
// Stopwatch-game sequencer. Drives the 00..99 counter into led_strip and reads back its
// led_o. Takes a player button press, scores a hit when the stop lands on a lit LED, and
// tracks lives. Above led_strip, below the 7-seg/score display logic.
// PARAMETERS
// LED_NUM    10   LEDs in strip (matches led_strip)
// CNT_LIM    100  counter modulus; cnt runs 0..CNT_LIM-1
// LIVES      3    misses allowed before game over
// STEP_INIT  8    tick_i strobes per count step at game start
// STEP_MIN   2    fastest step period (floor for speed-up)
// HOLD_TICKS 50   tick_i strobes result is frozen after a stop
// PORTS
// clk_i    in   1                 system clock
// rst_n_i  in   1                 async reset, active low
// tick_i   in   1                 1-cycle base time strobe
// btn_i    in   1                 player button, debounced+synchronised level, active high
// led_i    in   LED_NUM           led_o fed back from led_strip
// cnt_o    out  $clog2(CNT_LIM)+1 counter value to led_strip cnt_i
// score_o  out  $clog2(CNT_LIM)+1 hits this game, saturating
// lives_o  out  $clog2(LIVES+1)   remaining lives
// state_o  out  2                 game_pkg::state_t
// hit_o    out  1                 1-cycle pulse on scored stop
// miss_o   out  1                 1-cycle pulse on missed stop
// BEHAVIOUR
// - One clock: clk_i. rst_n_i is asynchronous and active low.
// - Reset values: state IDLE, cnt_o=0, score_o=0, lives_o=LIVES, step period=STEP_INIT,
//   sub/hold counters=0, hit_o=miss_o=0, btn_q=0.
// - press = btn_i & ~btn_q. btn_q is registered every cycle. Only rising edges act.
// - IDLE: cnt_o holds 0. On press: score_o<=0, lives_o<=LIVES, period<=STEP_INIT, sub<=0,
//   go RUN.
// - RUN: on tick_i, sub++. When sub==period-1, sub<=0 and cnt_o advances.
//   cnt_o wraps CNT_LIM-1 -> 0.
// - RUN + press: hit = |led_i in the same cycle (led_strip is combinational on cnt_o).
//   - hit:  hit_o=1 next cycle. score_o++ saturating at CNT_LIM-1. period<=max(period-1,STEP_MIN).
//   - miss: miss_o=1 next cycle. lives_o-- (never below 0).
//   - Either way go HOLD with hold cnt=0.
// - RUN with press and tick_i in the same cycle: the press wins. cnt_o and sub do not
//   advance that cycle.
// - HOLD: cnt_o frozen, presses ignored. Hold cnt++ on tick_i. After HOLD_TICKS ticks:
//   lives_o==0 -> OVER, else RUN with sub<=0. cnt_o resumes from its frozen value.
// - OVER: cnt_o, score_o frozen. Press -> IDLE (cnt_o<=0, score kept until next start).
// - Latency: press edge to hit_o/miss_o/state_o change = 1 clk. tick_i to cnt_o = 1 clk.
// - btn_i held high across states triggers nothing further until released and re-pressed.
// - Reset asserted mid-game: immediate return to reset values, no pulse emitted.
// - All widths are unsigned. Compare period against STEP_MIN before decrementing.
// STRUCTURE
// - game_pkg: state_t enum {IDLE, RUN, HOLD, OVER} (2 bit), LED_NUM/CNT_LIM defaults,
//   CNT_W = $clog2(CNT_LIM).
// - Sub-module step_div: programmable tick_i divider (period_i, en_i, clr_i -> step_o).
//   The FSM, counters and scoring stay in game_ctrl.
// TESTING (bench instantiates game_ctrl + led_strip, sw_i='1 unless noted, tick_i every 5 clk)
// - reset mid-RUN at cnt=37 -> all outputs at reset values asynchronously, state IDLE, cnt_o=0.
// - press in IDLE -> RUN, lives_o=3, score_o=0; cnt_o steps 0,1,2.. every 8 ticks; 99 -> 0 wrap.
// - press at cnt_o=45 -> hit_o pulse 1 clk, score_o=1, HOLD 50 ticks with cnt_o=45,
//   then RUN with period 7.
// - sw_i=0, press 3 times -> 3 miss_o pulses, lives_o 3->2->1->0, OVER after 3rd HOLD;
//   press -> IDLE.
// - 10 consecutive hits -> period floors at 2. Force score_o to 99, hit -> stays 99.
// - press coincident with tick_i in RUN -> cnt_o not advanced. btn_i held high through
//   HOLD->RUN -> no second stop.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared types and default sizing for the stopwatch game sequencer.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int LED_NUM_DEF = 10;
    localparam int CNT_LIM_DEF = 100;
    localparam int LIVES_DEF   = 3;
    localparam int CNT_W       = $clog2(CNT_LIM_DEF);

endpackage

// File: rtl/game_ctrl_if.sv
// Player/strip-facing signal bundle of game_ctrl; slave is the controller side.
interface game_ctrl_if #(
    parameter int LED_NUM = game_pkg::LED_NUM_DEF,
    parameter int CNT_LIM = game_pkg::CNT_LIM_DEF,
    parameter int LIVES   = game_pkg::LIVES_DEF
) ();
    import game_pkg::*;

    logic                       tick_i;
    logic                       btn_i;
    logic [LED_NUM-1:0]         led_i;
    logic [$clog2(CNT_LIM):0]   cnt_o;
    logic [$clog2(CNT_LIM):0]   score_o;
    logic [$clog2(LIVES+1)-1:0] lives_o;
    state_t                     state_o;
    logic                       hit_o;
    logic                       miss_o;

    modport slave (
        input  tick_i, btn_i, led_i,
        output cnt_o, score_o, lives_o, state_o, hit_o, miss_o
    );

    modport master (
        output tick_i, btn_i, led_i,
        input  cnt_o, score_o, lives_o, state_o, hit_o, miss_o
    );

endinterface

// File: rtl/game_ctrl_step_div.sv
// Programmable divider of the base tick: step_o fires on the period-th enabled tick.
module step_div #(
    parameter int PW = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [PW-1:0] period_i,
    output logic          step_o
);
    logic [PW-1:0] sub_q;
    logic          wrap_s;

    // Last sub-count of the current period; combinational so the step lands one clock after the tick.
    always_comb begin
        wrap_s = (sub_q == (period_i - PW'(1)));
        step_o = en_i & wrap_s;
    end

    // Sub-count of enabled ticks within one step period.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sub_q <= PW'(0);
        end else if (clr_i) begin
            sub_q <= PW'(0);
        end else if (en_i) begin
            sub_q <= wrap_s ? PW'(0) : sub_q + PW'(1);
        end else begin
            sub_q <= sub_q;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Stopwatch-game sequencer: steps the LED counter, scores stops against the lit LED
// fed back from led_strip, and tracks lives through IDLE/RUN/HOLD/OVER.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LED_NUM    = LED_NUM_DEF,
    parameter int CNT_LIM    = CNT_LIM_DEF,
    parameter int LIVES      = LIVES_DEF,
    parameter int STEP_INIT  = 8,
    parameter int STEP_MIN   = 2,
    parameter int HOLD_TICKS = 50
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    game_ctrl_if.slave g
);
    localparam int CW = $clog2(CNT_LIM) + 1;
    localparam int LW = $clog2(LIVES + 1);
    localparam int PW = $clog2(STEP_INIT + 1);
    localparam int HW = $clog2(HOLD_TICKS) + 1;

    state_t             state_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      score_q, score_d;
    logic [LW-1:0]      lives_q, lives_d;
    logic [PW-1:0]      period_q, period_d;
    logic [HW-1:0]      hold_q;
    logic               btn_q, hit_q, miss_q;
    logic [LED_NUM-1:0] led_s;
    logic               press_s, lit_s, step_s, step_en_s, step_clr_s, hold_done_s;

    // Edge detect on the button and derived enables for the divider and hold timer.
    always_comb begin
        led_s       = g.led_i;
        lit_s       = |led_s;
        press_s     = g.btn_i & ~btn_q;
        step_en_s   = g.tick_i & (state_q == RUN) & ~press_s;
        step_clr_s  = (state_q != RUN);
        hold_done_s = g.tick_i & (hold_q == HW'(HOLD_TICKS - 1));
    end

    // Saturating / wrapping next values; period is compared before it is decremented.
    always_comb begin
        cnt_d = (cnt_q == CW'(CNT_LIM - 1)) ? CW'(0) : cnt_q + CW'(1);
        if (score_q >= CW'(CNT_LIM - 1)) begin
            score_d = score_q;
        end else begin
            score_d = score_q + CW'(1);
        end
        if (period_q > PW'(STEP_MIN)) begin
            period_d = period_q - PW'(1);
        end else begin
            period_d = PW'(STEP_MIN);
        end
        if (lives_q != LW'(0)) begin
            lives_d = lives_q - LW'(1);
        end else begin
            lives_d = LW'(0);
        end
    end

    step_div #(.PW(PW)) u_step_div (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (step_en_s),
        .clr_i    (step_clr_s),
        .period_i (period_q),
        .step_o   (step_s)
    );

    // Game FSM with counter, score, lives, speed and result pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= CW'(0);
            score_q  <= CW'(0);
            lives_q  <= LW'(LIVES);
            period_q <= PW'(STEP_INIT);
            hold_q   <= HW'(0);
            btn_q    <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            btn_q  <= g.btn_i;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= CW'(0);
                    if (press_s) begin
                        score_q  <= CW'(0);
                        lives_q  <= LW'(LIVES);
                        period_q <= PW'(STEP_INIT);
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    // A press in the same cycle as a tick wins: the divider is held off.
                    if (press_s) begin
                        if (lit_s) begin
                            hit_q    <= 1'b1;
                            score_q  <= score_d;
                            period_q <= period_d;
                        end else begin
                            miss_q  <= 1'b1;
                            lives_q <= lives_d;
                        end
                        hold_q  <= HW'(0);
                        state_q <= HOLD;
                    end else if (step_s) begin
                        cnt_q <= cnt_d;
                    end
                end
                HOLD: begin
                    if (hold_done_s) begin
                        hold_q  <= HW'(0);
                        state_q <= (lives_q == LW'(0)) ? OVER : RUN;
                    end else if (g.tick_i) begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                OVER: begin
                    if (press_s) begin
                        cnt_q   <= CW'(0);
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign g.cnt_o   = cnt_q;
    assign g.score_o = score_q;
    assign g.lives_o = lives_q;
    assign g.state_o = state_q;
    assign g.hit_o   = hit_q;
    assign g.miss_o  = miss_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a behavioural one-hot LED strip on the feedback path.
module tb_game_ctrl;
    import game_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [9:0] sw;
    int         phase;
    logic       last_tick;
    int         n_chk;
    int         n_fail;
    int         n;
    int         p;
    logic [7:0] c_s;

    game_ctrl_if g_if ();

    game_ctrl dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .g       (g_if)
    );

    // LED strip model: the LED at cnt mod 10 lights when its switch is on.
    assign g_if.led_i = sw & (10'b1 << (g_if.cnt_o % 8'd10));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock; tick_i strobes every fifth cycle. Outputs are valid on return.
    task automatic cyc();
        g_if.tick_i = (phase == 4);
        last_tick   = g_if.tick_i;
        @(posedge clk);
        #1;
        phase = (phase + 1) % 5;
    endtask

    task automatic wait_hold(output int ticks, output int pulses);
        ticks  = 0;
        pulses = 0;
        for (int i = 0; i < 400 && g_if.state_o == HOLD; i++) begin
            cyc();
            if (last_tick) ticks++;
            if (g_if.hit_o | g_if.miss_o) pulses++;
        end
    endtask

    task automatic ticks_to_step(output int ticks);
        logic [7:0] c0;
        c0    = g_if.cnt_o;
        ticks = 0;
        for (int i = 0; i < 300 && g_if.cnt_o == c0; i++) begin
            cyc();
            if (last_tick) ticks++;
        end
    endtask

    task automatic wait_cnt(input string tag, input int v, input int budget);
        for (int i = 0; i < budget && int'(g_if.cnt_o) != v; i++) cyc();
        check_val(tag, g_if.cnt_o, v);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; phase = 0; last_tick = 1'b0;
        rst_n = 1'b0; sw = 10'h3FF;
        g_if.btn_i = 1'b0; g_if.tick_i = 1'b0;
        repeat (3) cyc();
        check_val("rst_state", g_if.state_o, IDLE);
        check_val("rst_cnt", g_if.cnt_o, 0);
        check_val("rst_score", g_if.score_o, 0);
        check_val("rst_lives", g_if.lives_o, 3);
        check_val("rst_pulses", {g_if.hit_o, g_if.miss_o}, 0);
        rst_n = 1'b1;
        cyc();

        // Start, step cadence at period 8, and the 99 -> 0 wrap.
        g_if.btn_i = 1'b1; cyc(); g_if.btn_i = 1'b0;
        check_val("start_state", g_if.state_o, RUN);
        check_val("start_lives", g_if.lives_o, 3);
        check_val("start_cnt", g_if.cnt_o, 0);
        ticks_to_step(n);
        check_val("step1_ticks", n, 8);
        check_val("step1_cnt", g_if.cnt_o, 1);
        check_val("step_on_tick", last_tick, 1);
        ticks_to_step(n);
        check_val("step2_ticks", n, 8);
        check_val("step2_cnt", g_if.cnt_o, 2);
        wait_cnt("reach_99", 99, 5000);
        ticks_to_step(n);
        check_val("wrap_cnt", g_if.cnt_o, 0);
        check_val("wrap_ticks", n, 8);

        // Hit at 45, frozen hold of 50 ticks, then faster period.
        wait_cnt("reach_45", 45, 3000);
        g_if.btn_i = 1'b1; cyc(); g_if.btn_i = 1'b0;
        check_val("hit45_pulse", g_if.hit_o, 1);
        check_val("hit45_miss", g_if.miss_o, 0);
        check_val("hit45_state", g_if.state_o, HOLD);
        check_val("hit45_score", g_if.score_o, 1);
        wait_hold(n, p);
        check_val("hold_ticks", n, 50);
        check_val("hit_pulse_width", p, 0);
        check_val("hold_exit_state", g_if.state_o, RUN);
        check_val("hold_frozen_cnt", g_if.cnt_o, 45);
        ticks_to_step(n);
        check_val("period7_ticks", n, 7);
        check_val("resume_cnt", g_if.cnt_o, 46);

        // Press on the tick that would step: counter must not advance.
        n = 0;
        while (n < 6) begin cyc(); if (last_tick) n++; end
        while (phase != 4) cyc();
        g_if.btn_i = 1'b1; cyc();
        check_val("coinc_cnt", g_if.cnt_o, 46);
        check_val("coinc_state", g_if.state_o, HOLD);
        check_val("coinc_score", g_if.score_o, 2);
        wait_hold(n, p);
        check_val("held_btn_hold_ticks", n, 50);
        check_val("held_btn_run", g_if.state_o, RUN);
        p = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (g_if.state_o != RUN || g_if.hit_o || g_if.miss_o) p++;
        end
        check_val("held_btn_no_stop", p, 0);
        g_if.btn_i = 1'b0;

        // Asynchronous reset mid-RUN at 37.
        wait_cnt("reach_37", 37, 6000);
        rst_n = 1'b0;
        #2;
        check_val("arst_state", g_if.state_o, IDLE);
        check_val("arst_cnt", g_if.cnt_o, 0);
        check_val("arst_score", g_if.score_o, 0);
        check_val("arst_lives", g_if.lives_o, 3);
        p = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (g_if.hit_o || g_if.miss_o || g_if.state_o != IDLE) p++;
        end
        check_val("arst_hold", p, 0);
        rst_n = 1'b1;
        cyc();

        // Three misses end the game.
        sw = 10'h000;
        g_if.btn_i = 1'b1; cyc(); g_if.btn_i = 1'b0; cyc();
        for (int i = 0; i < 3; i++) begin
            g_if.btn_i = 1'b1; cyc(); g_if.btn_i = 1'b0;
            check_val("miss_pulse", g_if.miss_o, 1);
            check_val("miss_no_hit", g_if.hit_o, 0);
            check_val("miss_lives", g_if.lives_o, 2 - i);
            wait_hold(n, p);
            check_val("miss_after_hold", g_if.state_o, (i < 2) ? RUN : OVER);
        end
        c_s = g_if.cnt_o;
        repeat (50) cyc();
        check_val("over_cnt_frozen", g_if.cnt_o, c_s);
        check_val("over_state", g_if.state_o, OVER);
        g_if.btn_i = 1'b1; cyc(); g_if.btn_i = 1'b0;
        check_val("over_to_idle", g_if.state_o, IDLE);
        check_val("over_cnt_clr", g_if.cnt_o, 0);
        cyc();

        // Ten hits floor the period at 2; score saturates at 99.
        sw = 10'h3FF;
        g_if.btn_i = 1'b1; cyc(); g_if.btn_i = 1'b0; cyc();
        for (int h = 1; h <= 10; h++) begin
            g_if.btn_i = 1'b1; cyc(); g_if.btn_i = 1'b0;
            check_val("run_hit", g_if.hit_o, 1);
            check_val("run_score", g_if.score_o, h);
            wait_hold(n, p);
        end
        ticks_to_step(n);
        check_val("period_floor", n, 2);
        for (int h = 11; h <= 99; h++) begin
            g_if.btn_i = 1'b1; cyc(); g_if.btn_i = 1'b0;
            wait_hold(n, p);
        end
        check_val("score_99", g_if.score_o, 99);
        check_val("lives_kept", g_if.lives_o, 3);
        g_if.btn_i = 1'b1; cyc(); g_if.btn_i = 1'b0;
        check_val("sat_hit", g_if.hit_o, 1);
        check_val("sat_score", g_if.score_o, 99);
        wait_hold(n, p);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
